// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one fetch at a time, hands words to decode.
// Optional performance counters are enabled by defining IFU_PERF_CNT_EN.
module ifu_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter logic [31:0] HALT_WORD = 32'h0000_0000
`ifdef IFU_PERF_CNT_EN
    ,
    parameter int          PERF_W    = 32
`endif
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted,
    output logic [2:0]  dbg_state
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] perf_fetch_cnt,
    output logic [PERF_W-1:0] perf_stall_cnt,
    output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

    typedef enum logic [2:0] {
        S_REQ   = 3'd0,
        S_WAIT  = 3'd1,
        S_DRAIN = 3'd2,
        S_HOLD  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic [31:0] w_redir_pc;

    assign w_redir_pc = redirect_pc & 32'hFFFF_FFFC;

    // Handshakes: a request transfers when imem_req_valid && imem_req_ready at posedge;
    // a response is a one-cycle imem_rsp_valid pulse; decode takes inst when inst_valid && inst_ready.
    assign imem_req_valid = (r_state == S_REQ);
    assign imem_req_addr  = r_pc;
    assign inst_valid     = (r_state == S_HOLD);
    assign inst           = r_inst;
    assign inst_pc        = r_inst_pc;
    assign halted         = (r_state == S_HALT);
    assign dbg_state      = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_REQ;
            r_pc      <= RESET_PC;
            r_inst    <= 32'h0;
            r_inst_pc <= 32'h0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (redirect_valid) begin
                        r_pc    <= w_redir_pc;
                        r_state <= imem_req_ready ? S_DRAIN : S_REQ;
                    end else if (imem_req_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        r_pc    <= w_redir_pc;
                        r_state <= imem_rsp_valid ? S_REQ : S_DRAIN;
                    end else if (imem_rsp_valid) begin
                        if (imem_rsp_data == HALT_WORD) begin
                            r_state <= S_HALT;
                        end else begin
                            r_inst    <= imem_rsp_data;
                            r_inst_pc <= r_pc;
                            r_pc      <= r_pc + 32'd4;
                            r_state   <= S_HOLD;
                        end
                    end
                end
                S_DRAIN: begin
                    // A redirect coinciding with the stale response still consumes it.
                    if (redirect_valid) begin
                        r_pc <= w_redir_pc;
                    end
                    if (imem_rsp_valid) begin
                        r_state <= S_REQ;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        r_pc    <= w_redir_pc;
                        r_state <= S_REQ;
                    end else if (inst_ready) begin
                        r_state <= S_REQ;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_REQ;
                end
            endcase
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [PERF_W-1:0] r_fetch_cnt;
    logic [PERF_W-1:0] r_stall_cnt;
    logic [PERF_W-1:0] r_flush_cnt;
    logic              w_fetch_inc;
    logic              w_stall_inc;
    logic              w_flush_inc;

    // A squashed HOLD (redirect with inst_ready) does not count as a delivered fetch.
    assign w_fetch_inc = (r_state == S_HOLD) && inst_ready && !redirect_valid;
    assign w_stall_inc = ((r_state == S_REQ) && !imem_req_ready) || (r_state == S_WAIT);
    assign w_flush_inc = redirect_valid && (r_state != S_HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_fetch_inc && (r_fetch_cnt != '1)) r_fetch_cnt <= r_fetch_cnt + 1'b1;
            if (w_stall_inc && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush_inc && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign perf_fetch_cnt = r_fetch_cnt;
    assign perf_stall_cnt = r_stall_cnt;
    assign perf_flush_cnt = r_flush_cnt;
`endif

endmodule
